// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU/result mux between NREQ requesters.
// Accept in IDLE, drive the ALU for one EXEC cycle, return the tagged result in DONE.

module alu_share_lane #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int IDX   = 0
) (
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] rank
);
    // Distance of this lane from the slot after the last winner; 0 is top priority.
    always_comb begin
        int r;
        r    = (IDX + 2 * NREQ - int'(last) - 1) % NREQ;
        rank = ID_W'(r);
    end
endmodule

module alu_share_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     op_i,
    input  logic [WIDTH*NREQ-1:0] a_i,
    input  logic [WIDTH*NREQ-1:0] b_i,
    output logic [NREQ-1:0]       gnt,
    output logic [2:0]            alu_ctrl,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_res,
    output logic [WIDTH-1:0]      res_o,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_valid,
    output logic                  op_err,
    output logic                  busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                 state;
    logic [ID_W-1:0]            last;
    logic [2:0]                 op_q;
    logic [WIDTH-1:0]           a_q;
    logic [WIDTH-1:0]           b_q;
    logic [NREQ-1:0][ID_W-1:0]  rank;
    logic [ID_W-1:0]            win;
    logic                       found;
    logic [ID_W-1:0]            best;

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        alu_share_lane #(
            .WIDTH (WIDTH),
            .NREQ  (NREQ),
            .ID_W  (ID_W),
            .IDX   (k)
        ) u_lane (
            .last (last),
            .rank (rank[k])
        );
    end

    // Lowest rank among active requesters wins; ranks are unique so no tie-break is needed.
    always_comb begin
        found = 1'b0;
        best  = '0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req[k] && (!found || rank[k] < best)) begin
                found = 1'b1;
                best  = rank[k];
                win   = ID_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= ID_W'(NREQ - 1);
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt       <= '0;
            res_o     <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_q  <= op_i[3*win +: 3];
                        a_q   <= a_i[WIDTH*win +: WIDTH];
                        b_q   <= b_i[WIDTH*win +: WIDTH];
                        gnt   <= NREQ'(1) << win;
                        last  <= win;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    res_o     <= alu_res;
                    res_id    <= last;
                    op_err    <= (op_q > 3'd4);
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    gnt       <= '0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Latched regs only change on acceptance, so the ALU inputs hold outside EXEC.
    assign alu_ctrl = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: bench-side ALU/result mux plus a result scoreboard.

module tb_alu_share_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;

    typedef struct {
        int         id;
        logic [3:0] res;
        logic       err;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [3*NREQ-1:0]     op_i;
    logic [WIDTH*NREQ-1:0] a_i;
    logic [WIDTH*NREQ-1:0] b_i;
    logic [NREQ-1:0]       gnt;
    logic [2:0]            alu_ctrl;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [WIDTH-1:0]      alu_res;
    logic [WIDTH-1:0]      res_o;
    logic [ID_W-1:0]       res_id;
    logic                  res_valid;
    logic                  op_err;
    logic                  busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .gnt       (gnt),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .res_o     (res_o),
        .res_id    (res_id),
        .res_valid (res_valid),
        .op_err    (op_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ALU plus 5-way result mux; selects 5..7 fall through to input 4.
    always_comb begin
        case (alu_ctrl)
            3'd0:    alu_res = alu_a + alu_b;
            3'd1:    alu_res = alu_a - alu_b;
            3'd2:    alu_res = alu_a & alu_b;
            3'd3:    alu_res = alu_a | alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every res_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(res_id), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_o", 32'(res_o), 32'(e.res));
                chk("op_err", 32'(op_err), 32'(e.err));
            end
        end
    end

    task automatic set_lane(input int k, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        op_i[3*k +: 3] = op;
        a_i[4*k +: 4]  = a;
        b_i[4*k +: 4]  = b;
    endtask

    task automatic push_exp(input int k, input logic [3:0] r, input logic e);
        exp_t x;
        x.id  = k;
        x.res = r;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input int k);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) break;
        end
        chk("gnt_onehot", 32'(gnt), 32'(1) << k);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic issue(input int k, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] r);
        set_lane(k, op, a, b);
        req[k] = 1'b1;
        push_exp(k, r, op > 3'd4);
        wait_gnt(k);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(op));
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("busy_exec", 32'(busy), 32'd1);
        req[k] = 1'b0;
        @(negedge clk);
        chk("latency", 32'(res_valid), 32'd1);
        wait_idle();
    endtask

    initial begin
        int last_cyc;
        bit saw3;
        rst_n = 1'b0;
        req   = '0;
        op_i  = '0;
        a_i   = '0;
        b_i   = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", 32'(res_o), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_err", 32'(op_err), 32'd0);
        chk("rst_alu", {alu_ctrl, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add, then results must hold after the pulse.
        issue(0, 3'd0, 4'd3, 4'd5, 4'd8);
        chk("valid_drop", 32'(res_valid), 32'd0);
        chk("res_hold", 32'(res_o), 32'd8);
        chk("gnt_drop", 32'(gnt), 32'd0);

        // Subtract with wrap: 2 - 7 = B.
        issue(1, 3'd1, 4'd2, 4'd7, 4'hB);

        // Illegal op 6 routes to the xor path and flags op_err.
        issue(2, 3'd6, 4'hA, 4'h3, 4'h9);

        // All four requesting from reset: order 0,1,2,3,0, issue every 3 cycles.
        rst_n = 1'b0;
        for (int k = 0; k < NREQ; k++) set_lane(k, 3'd4, 4'(k + 1), 4'(15 - k));
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) push_exp(g % 4, 4'((g % 4) + 1) ^ 4'(15 - (g % 4)), 1'b0);
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(g % 4);
            if (g > 0) chk("issue_period", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
        end
        req = '0;
        wait_idle();
        @(negedge clk);

        // Reset during EXEC aborts the operation.
        set_lane(1, 3'd0, 4'd1, 4'd1);
        req[1] = 1'b1;
        wait_gnt(1);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", 32'(res_o), 32'd0);
        rst_n = 1'b1;
        set_lane(0, 3'd3, 4'h5, 4'hA);
        push_exp(0, 4'hF, 1'b0);
        req = 4'b1111;
        wait_gnt(0);
        req = '0;
        @(negedge clk);
        chk("post_rst_latency", 32'(res_valid), 32'd1);
        wait_idle();

        // req[3] pulsed during EXEC is ignored and never granted.
        set_lane(0, 3'd2, 4'hC, 4'hA);
        req[0] = 1'b1;
        push_exp(0, 4'h8, 1'b0);
        wait_gnt(0);
        req[0] = 1'b0;
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        saw3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt[3]) saw3 = 1'b1;
        end
        chk("ignored_req3", 32'(saw3), 32'd0);
        chk("stay_idle", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
